// File: rtl/yutorina_gpr_wb_pkg.sv
// Shared GPR definitions plus the writeback FIFO sizing.
// Exports: GPR address/data widths, GPR_NUM, GPR_ZERO, active-low enable
// levels, FIFO depth/pointer width, and the FIFO entry struct.
package yutorina_gpr_wb_pkg;

   localparam int GPR_ADDR_W  = 5;
   localparam int GPR_NUM     = 32;
   localparam int WORD_DATA_W = 32;

   localparam int GPR_WB_FIFO_DEPTH = 2;
   localparam int GPR_WB_PTR_W      = $clog2(GPR_WB_FIFO_DEPTH);

   typedef logic [GPR_ADDR_W-1:0]   gpr_addr_t;
   typedef logic [WORD_DATA_W-1:0]  word_data_t;
   typedef logic [GPR_WB_PTR_W-1:0] gpr_wb_ptr_t;

   localparam gpr_addr_t GPR_ZERO = '0;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef struct packed {
      gpr_addr_t  addr;
      word_data_t data;
   } wb_entry_t;

endpackage

// File: rtl/yutorina_gpr_wb_fifo.sv
// Synchronous FIFO buffering long-latency (B) writeback results.
// Ports: clk/rst, push/din (write side), pop/dout (read side, dout is the
// head entry), full/empty status flags.
// Full and empty are kept as separate registered flags, so every slot is
// usable. Push while full and pop while empty are ignored.
module yutorina_gpr_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_nxt;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok    = push & ~full;
   assign pop_ok     = pop & ~empty;
   assign wr_ptr_nxt = wr_ptr + 1'b1;
   assign rd_ptr_nxt = rd_ptr + 1'b1;
   assign dout       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr_nxt;
         end
         // simultaneous push and pop leaves occupancy, and both flags, alone
         if (push_ok && !pop_ok) begin
            empty <= 1'b0;
            full  <= (wr_ptr_nxt == rd_ptr);
         end else if (pop_ok && !push_ok) begin
            full  <= 1'b0;
            empty <= (rd_ptr_nxt == wr_ptr);
         end
      end
   end

endmodule

// File: rtl/yutorina_gpr_wb.sv
// GPR writeback: owns the register file's single write port.
// Ports:
//   clk, rst                 clock, async active-high reset
//   a_en_/a_addr/a_data      in-order results, always accepted, top priority
//   b_valid/b_ready/b_addr/b_data  long-latency results, buffered in a FIFO
//   iss_en_/iss_addr         long-latency issue, marks destination pending
//   q_addr1/busy1, q_addr2/busy2   pending-scoreboard queries
//   we_/w_addr/w_data        registered GPR write port (we_ active-low)
module yutorina_gpr_wb
   import yutorina_gpr_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = GPR_WB_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_en_,
   input  gpr_addr_t  a_addr,
   input  word_data_t a_data,
   input  logic       b_valid,
   output logic       b_ready,
   input  gpr_addr_t  b_addr,
   input  word_data_t b_data,
   input  logic       iss_en_,
   input  gpr_addr_t  iss_addr,
   input  gpr_addr_t  q_addr1,
   output logic       busy1,
   input  gpr_addr_t  q_addr2,
   output logic       busy2,
   output logic       we_,
   output gpr_addr_t  w_addr,
   output word_data_t w_data
);

   wb_entry_t          b_in;
   wb_entry_t          head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               a_fire;
   logic               head_zero;
   logic               b_write;
   logic [GPR_NUM-1:0] pending;

   assign b_in    = '{addr: b_addr, data: b_data};
   assign b_ready = ~full;
   assign push    = b_valid & ~full;

   assign a_fire    = (a_en_ == ENABLE_) && (a_addr != GPR_ZERO);
   assign head_zero = (head.addr == GPR_ZERO);
   // an r0 entry never uses the write port, so it drains alongside an A write
   assign pop       = ~empty & (~a_fire | head_zero);
   assign b_write   = pop & ~head_zero;

   yutorina_gpr_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (b_in),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_    <= DISABLE_;
         w_addr <= GPR_ZERO;
         w_data <= '0;
      end else if (a_fire) begin
         we_    <= ENABLE_;
         w_addr <= a_addr;
         w_data <= a_data;
      end else if (b_write) begin
         we_    <= ENABLE_;
         w_addr <= head.addr;
         w_data <= head.data;
      end else begin
         we_    <= DISABLE_;
      end
   end

   // set is written last so a same-edge issue wins over the commit clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (b_write) begin
            pending[head.addr] <= 1'b0;
         end
         if ((iss_en_ == ENABLE_) && (iss_addr != GPR_ZERO)) begin
            pending[iss_addr] <= 1'b1;
         end
      end
   end

   assign busy1 = pending[q_addr1];
   assign busy2 = pending[q_addr2];

endmodule

// File: tb/tb_yutorina_gpr_wb.sv
module tb_yutorina_gpr_wb;
   import yutorina_gpr_wb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_en_;
   gpr_addr_t  a_addr;
   word_data_t a_data;
   logic       b_valid;
   logic       b_ready;
   gpr_addr_t  b_addr;
   word_data_t b_data;
   logic       iss_en_;
   gpr_addr_t  iss_addr;
   gpr_addr_t  q_addr1;
   logic       busy1;
   gpr_addr_t  q_addr2;
   logic       busy2;
   logic       we_;
   gpr_addr_t  w_addr;
   word_data_t w_data;

   always #5 clk = ~clk;

   yutorina_gpr_wb #(.FIFO_DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_en_    (a_en_),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .iss_en_  (iss_en_),
      .iss_addr (iss_addr),
      .q_addr1  (q_addr1),
      .busy1    (busy1),
      .q_addr2  (q_addr2),
      .busy2    (busy2),
      .we_      (we_),
      .w_addr   (w_addr),
      .w_data   (w_data)
   );

   // inputs for one cycle; e_rdy/e_busy* are checked before the edge,
   // e_we_/e_waddr/e_wdata are the output register after that edge
   typedef struct {
      logic       a_en_;
      gpr_addr_t  a_addr;
      word_data_t a_data;
      logic       b_valid;
      gpr_addr_t  b_addr;
      word_data_t b_data;
      logic       iss_en_;
      gpr_addr_t  iss_addr;
      gpr_addr_t  q1;
      gpr_addr_t  q2;
      logic       e_rdy;
      logic       e_busy1;
      logic       e_busy2;
      logic       e_we_;
      gpr_addr_t  e_waddr;
      word_data_t e_wdata;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(int ae, int aa, int ad, int bv, int ba, int bd,
                               int ie, int ia, int q1, int q2,
                               int rdy, int b1, int b2, int we, int wa, int wd);
      vec_t v;
      v.a_en_    = logic'(ae);
      v.a_addr   = gpr_addr_t'(aa);
      v.a_data   = word_data_t'(ad);
      v.b_valid  = logic'(bv);
      v.b_addr   = gpr_addr_t'(ba);
      v.b_data   = word_data_t'(bd);
      v.iss_en_  = logic'(ie);
      v.iss_addr = gpr_addr_t'(ia);
      v.q1       = gpr_addr_t'(q1);
      v.q2       = gpr_addr_t'(q2);
      v.e_rdy    = logic'(rdy);
      v.e_busy1  = logic'(b1);
      v.e_busy2  = logic'(b2);
      v.e_we_    = logic'(we);
      v.e_waddr  = gpr_addr_t'(wa);
      v.e_wdata  = word_data_t'(wd);
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      a_en_    = v.a_en_;
      a_addr   = v.a_addr;
      a_data   = v.a_data;
      b_valid  = v.b_valid;
      b_addr   = v.b_addr;
      b_data   = v.b_data;
      iss_en_  = v.iss_en_;
      iss_addr = v.iss_addr;
      q_addr1  = v.q1;
      q_addr2  = v.q2;
   endtask

   task automatic idle();
      drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //       a_en_ a_addr a_data   b_v b_addr b_data    iss iaddr q1 q2  rdy b1 b2  we_ waddr wdata
      // A write latency
      vecs.push_back(mk(0, 3, 'h11,   0, 0,  0,        1, 0,   0, 0,   1, 0, 0,   0, 3, 'h11));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   0, 0,   1, 0, 0,   1, 3, 'h11));
      // B write latency and scoreboard clear
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 7,   7, 0,   1, 0, 0,   1, 3, 'h11));
      vecs.push_back(mk(1, 0, 0,      1, 7,  'hBEEF,   1, 0,   7, 0,   1, 1, 0,   1, 3, 'h11));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   7, 0,   1, 1, 0,   0, 7, 'hBEEF));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   7, 0,   1, 0, 0,   1, 7, 'hBEEF));
      // A busy for 4 cycles while B sends r8, r9, r10
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 8,   8, 0,   1, 0, 0,   1, 7, 'hBEEF));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 9,   8, 9,   1, 1, 0,   1, 7, 'hBEEF));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 10,  9, 10,  1, 1, 0,   1, 7, 'hBEEF));
      vecs.push_back(mk(0, 1, 'hA1,   1, 8,  'h88,     1, 0,   8, 10,  1, 1, 1,   0, 1, 'hA1));
      vecs.push_back(mk(0, 2, 'hA2,   1, 9,  'h99,     1, 0,   8, 9,   1, 1, 1,   0, 2, 'hA2));
      vecs.push_back(mk(0, 3, 'hA3,   1, 10, 'hAA,     1, 0,   8, 10,  0, 1, 1,   0, 3, 'hA3));
      vecs.push_back(mk(0, 4, 'hA4,   1, 10, 'hAA,     1, 0,   9, 10,  0, 1, 1,   0, 4, 'hA4));
      vecs.push_back(mk(1, 0, 0,      1, 10, 'hAA,     1, 0,   8, 10,  0, 1, 1,   0, 8, 'h88));
      vecs.push_back(mk(1, 0, 0,      1, 10, 'hAA,     1, 0,   8, 9,   1, 0, 1,   0, 9, 'h99));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   9, 10,  1, 0, 1,   0, 10, 'hAA));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   10, 8,  1, 0, 0,   1, 10, 'hAA));
      // writes to r0 are dropped; r0 entries still drain, even beside an A write
      vecs.push_back(mk(0, 0, 'h5,    1, 0,  'h77,     1, 0,   7, 4,   1, 0, 0,   1, 10, 'hAA));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   0, 0,   1, 0, 0,   1, 10, 'hAA));
      vecs.push_back(mk(0, 0, 'h5,    1, 0,  'h66,     1, 0,   0, 0,   1, 0, 0,   1, 10, 'hAA));
      vecs.push_back(mk(0, 5, 'h55,   1, 0,  'h67,     1, 0,   5, 0,   1, 0, 0,   0, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   0, 0,   1, 0, 0,   1, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      1, 0,  'h68,     1, 0,   0, 0,   1, 0, 0,   1, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      1, 0,  'h69,     1, 0,   0, 0,   1, 0, 0,   1, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   7, 4,   1, 0, 0,   1, 5, 'h55));
      // issue and commit of r4 on the same edge: pending stays set
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 4,   4, 7,   1, 0, 0,   1, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      1, 4,  'h44,     1, 0,   4, 7,   1, 1, 0,   1, 5, 'h55));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        0, 4,   4, 7,   1, 1, 0,   0, 4, 'h44));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   4, 7,   1, 1, 0,   1, 4, 'h44));
      vecs.push_back(mk(1, 0, 0,      1, 4,  'h45,     1, 0,   4, 7,   1, 1, 0,   1, 4, 'h44));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   4, 7,   1, 1, 0,   0, 4, 'h45));
      vecs.push_back(mk(1, 0, 0,      0, 0,  0,        1, 0,   4, 7,   1, 0, 0,   1, 4, 'h45));

      rst = 1'b1;
      idle();
      #3;
      chk("reset we_",     32'(we_),     32'(1));
      chk("reset w_addr",  32'(w_addr),  32'(0));
      chk("reset w_data",  w_data,       32'(0));
      chk("reset b_ready", 32'(b_ready), 32'(1));
      chk("reset busy1",   32'(busy1),   32'(0));
      tick();
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("row%0d b_ready", i), 32'(b_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("row%0d busy1", i),   32'(busy1),   32'(vecs[i].e_busy1));
         chk($sformatf("row%0d busy2", i),   32'(busy2),   32'(vecs[i].e_busy2));
         tick();
         chk($sformatf("row%0d we_", i),     32'(we_),     32'(vecs[i].e_we_));
         chk($sformatf("row%0d w_addr", i),  32'(w_addr),  32'(vecs[i].e_waddr));
         chk($sformatf("row%0d w_data", i),  w_data,       vecs[i].e_wdata);
      end

      // reset with two queued B results and r5/r6 pending
      idle();
      iss_en_ = 1'b0; iss_addr = 5'd5;
      tick();
      iss_addr = 5'd6;
      tick();
      iss_en_ = 1'b1;
      a_en_ = 1'b0; a_addr = 5'd1; a_data = 32'hC1;
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h500;
      tick();
      a_addr = 5'd2; a_data = 32'hC2;
      b_addr = 5'd6; b_data = 32'h600;
      tick();
      a_addr = 5'd3; a_data = 32'hC3;
      b_valid = 1'b0;
      q_addr1 = 5'd5; q_addr2 = 5'd6;
      #1;
      chk("pre-reset b_ready", 32'(b_ready), 32'(0));
      chk("pre-reset busy1",   32'(busy1),   32'(1));
      chk("pre-reset we_",     32'(we_),     32'(0));
      #1;
      rst = 1'b1;
      #1;
      chk("mid reset we_",     32'(we_),     32'(1));
      chk("mid reset w_addr",  32'(w_addr),  32'(0));
      chk("mid reset w_data",  w_data,       32'(0));
      chk("mid reset busy1",   32'(busy1),   32'(0));
      chk("mid reset busy2",   32'(busy2),   32'(0));
      chk("mid reset b_ready", 32'(b_ready), 32'(1));
      tick();
      a_en_ = 1'b1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("post reset we_ %0d", k),   32'(we_),   32'(1));
         chk($sformatf("post reset busy1 %0d", k), 32'(busy1), 32'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
